// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding and bit-period helper,
// used by both the transmit and receive sides.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Clocks per line bit; clk_fre is in MHz.
   function automatic int calc_cycle(input int clk_fre, input int baud_rate);
      return (clk_fre * 1000000) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; read data is the head word (first-word fall-through),
// full/empty told apart by the extra pointer MSB.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk_sys,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (i_push && !o_full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (i_pop && !o_empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_push && !o_full)
         mem[wr_ptr[AW-1:0]] <= i_wdata;
   end

   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_empty = (wr_ptr == rd_ptr);
   assign o_level = wr_ptr - rd_ptr;
   assign o_rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO feeding a start/data/parity/stop frame FSM.
// Optional line break input i_break is enabled by defining UART_TX_BUF_BREAK_EN.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_FRE     = 50,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_ON   = 0,
   parameter int PARITY_TYPE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          i_clk_sys,
   input  logic                          i_rst,
`ifdef UART_TX_BUF_BREAK_EN
   input  logic                          i_break,
`endif
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic                          i_data_valid,
   output logic                          o_data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_busy,
   output logic                          o_uart_tx
);

   localparam int CYCLE    = calc_cycle(CLK_FRE, BAUD_RATE);
   localparam int STOP_LEN = STOP_BITS * CYCLE;
   localparam int CW       = $clog2(STOP_LEN + 1);
   localparam int IW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLE - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] DBIT_LAST = IW'(DATA_WIDTH - 1);
   localparam logic          PAR_ODD   = (PARITY_TYPE != 0);

   uart_state_e           state;
   logic [CW-1:0]         bit_cnt;
   logic [IW-1:0]         dbit;
   logic                  bit_end;
   logic                  brk;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [DATA_WIDTH-1:0] shift_p0;
   logic                  par_p0;

`ifdef UART_TX_BUF_BREAK_EN
   assign brk = i_break;
`else
   assign brk = 1'b0;
`endif

   uart_tx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk_sys (i_clk_sys),
      .i_rst     (i_rst),
      .i_push    (i_data_valid),
      .i_wdata   (i_data),
      .i_pop     (pop),
      .o_rdata   (fifo_rdata),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty),
      .o_level   (o_fifo_level)
   );

   assign o_data_ready = !fifo_full;
   assign bit_end      = (state == ST_STOP) ? (bit_cnt == STOP_LAST) : (bit_cnt == BIT_LAST);
   // Break is only honoured between frames, so it gates pops but never truncates a frame.
   assign pop = !fifo_empty && !brk && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

   // Stage p0: word and its parity captured at pop, shifted out LSB first
   always_ff @(posedge i_clk_sys) begin
      if (pop) begin
         shift_p0 <= fifo_rdata;
         par_p0   <= (^fifo_rdata) ^ PAR_ODD;
      end else if ((state == ST_DATA) && bit_end) begin
         shift_p0 <= shift_p0 >> 1;
      end
   end

   // Line and busy are registered from the current state, one clock behind it
   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         dbit      <= '0;
         o_uart_tx <= 1'b1;
         o_busy    <= 1'b0;
      end else begin
         o_busy <= (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               o_uart_tx <= !brk;
               if (pop) begin
                  state   <= ST_START;
                  bit_cnt <= '0;
               end
            end
            ST_START: begin
               o_uart_tx <= 1'b0;
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  dbit    <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            ST_DATA: begin
               o_uart_tx <= shift_p0[0];
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (dbit == DBIT_LAST)
                     state <= (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
                  else
                     dbit <= dbit + IDX_ONE;
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            ST_PARITY: begin
               o_uart_tx <= par_p0;
               if (bit_end) begin
                  state   <= ST_STOP;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            ST_STOP: begin
               o_uart_tx <= 1'b1;
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= pop ? ST_START : ST_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: stimulus queues expected frames, per-DUT
// monitors decode the serial lines sample by sample and compare.
module tb_uart_tx_buf;

   localparam int BIT_CYC = 50;

   typedef struct {
      logic [15:0] bits;
      int          ncyc;
      int          start_cyc;
      bit          contig;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int frame_id = 0;
   bit done     = 1'b0;
   logic [3:0] mon_en = 4'hF;

   exp_t q0[$], q1[$], q2[$], q3[$];

   int cfg_dw   [4] = '{8, 8, 8, 5};
   int cfg_par  [4] = '{0, 1, 1, 0};
   int cfg_odd  [4] = '{0, 1, 0, 0};
   int cfg_stop [4] = '{1, 1, 1, 2};

   logic       rst_a, rst_o, brk_po;
   logic       v_a, v_po, v_pe, v_s2;
   logic [7:0] d_a, d_po, d_pe;
   logic [4:0] d_s2;
   logic       rdy_a, rdy_po, rdy_pe, rdy_s2;
   logic [2:0] lvl_a;
   logic [4:0] lvl_po, lvl_pe, lvl_s2;
   logic       busy_a, busy_po, busy_pe, busy_s2;
   logic       tx_a, tx_po, tx_pe, tx_s2;

   uart_tx_buf #(.CLK_FRE(50), .BAUD_RATE(1000000), .FIFO_DEPTH(4)) dut_a (
      .i_clk_sys(clk), .i_rst(rst_a),
`ifdef UART_TX_BUF_BREAK_EN
      .i_break(1'b0),
`endif
      .i_data(d_a), .i_data_valid(v_a), .o_data_ready(rdy_a),
      .o_fifo_level(lvl_a), .o_busy(busy_a), .o_uart_tx(tx_a));

   uart_tx_buf #(.CLK_FRE(50), .BAUD_RATE(1000000), .PARITY_ON(1), .PARITY_TYPE(1)) dut_po (
      .i_clk_sys(clk), .i_rst(rst_o),
`ifdef UART_TX_BUF_BREAK_EN
      .i_break(brk_po),
`endif
      .i_data(d_po), .i_data_valid(v_po), .o_data_ready(rdy_po),
      .o_fifo_level(lvl_po), .o_busy(busy_po), .o_uart_tx(tx_po));

   uart_tx_buf #(.CLK_FRE(50), .BAUD_RATE(1000000), .PARITY_ON(1), .PARITY_TYPE(0)) dut_pe (
      .i_clk_sys(clk), .i_rst(rst_o),
`ifdef UART_TX_BUF_BREAK_EN
      .i_break(1'b0),
`endif
      .i_data(d_pe), .i_data_valid(v_pe), .o_data_ready(rdy_pe),
      .o_fifo_level(lvl_pe), .o_busy(busy_pe), .o_uart_tx(tx_pe));

   uart_tx_buf #(.CLK_FRE(50), .BAUD_RATE(1000000), .DATA_WIDTH(5), .STOP_BITS(2)) dut_s2 (
      .i_clk_sys(clk), .i_rst(rst_o),
`ifdef UART_TX_BUF_BREAK_EN
      .i_break(1'b0),
`endif
      .i_data(d_s2), .i_data_valid(v_s2), .o_data_ready(rdy_s2),
      .o_fifo_level(lvl_s2), .o_busy(busy_s2), .o_uart_tx(tx_s2));

   function automatic logic get_tx(input int k);
      case (k)
         0: return tx_a;
         1: return tx_po;
         2: return tx_pe;
         default: return tx_s2;
      endcase
   endfunction

   function automatic logic get_busy(input int k);
      case (k)
         0: return busy_a;
         1: return busy_po;
         2: return busy_pe;
         default: return busy_s2;
      endcase
   endfunction

   function automatic logic get_rdy(input int k);
      case (k)
         0: return rdy_a;
         1: return rdy_po;
         2: return rdy_pe;
         default: return rdy_s2;
      endcase
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic exp_t qpop(input int k);
      exp_t e;
      case (k)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         2: e = q2.pop_front();
         default: e = q3.pop_front();
      endcase
      return e;
   endfunction

   // Reference frame: start 0, data LSB first, optional parity, stop bits 1
   function automatic logic [15:0] frame_bits(input logic [8:0] d, input int k, output int n);
      logic [15:0] b;
      logic        p;
      b = '0;
      n = 1;
      p = cfg_odd[k][0];
      for (int i = 0; i < cfg_dw[k]; i++) begin
         b[n] = d[i];
         p    = p ^ d[i];
         n++;
      end
      if (cfg_par[k] != 0) begin
         b[n] = p;
         n++;
      end
      for (int s = 0; s < cfg_stop[k]; s++) begin
         b[n] = 1'b1;
         n++;
      end
      return b;
   endfunction

   task automatic enq(input int k, input logic [8:0] d, input bit contig, input int start, input int ncyc_lim);
      exp_t e;
      int   n;
      e.bits      = frame_bits(d, k, n);
      e.ncyc      = (ncyc_lim > 0) ? ncyc_lim : n * BIT_CYC;
      e.start_cyc = start;
      e.contig    = contig;
      e.id        = frame_id;
      frame_id++;
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic set_in(input int k, input logic [8:0] d, input logic v);
      case (k)
         0: begin d_a  = d[7:0]; v_a  = v; end
         1: begin d_po = d[7:0]; v_po = v; end
         2: begin d_pe = d[7:0]; v_pe = v; end
         default: begin d_s2 = d[4:0]; v_s2 = v; end
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
      end
   endtask

   // Called just after a negedge; returns at the negedge following acceptance.
   task automatic do_push(input int k, input logic [8:0] d, output int acc);
      int guard;
      guard = 0;
      set_in(k, d, 1'b1);
      while (get_rdy(k) !== 1'b1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         checks++;
         failures++;
         $display("FAIL push_ready_timeout dut%0d: ready=%b required=1", k, get_rdy(k));
         acc = -1;
      end else begin
         @(negedge clk);
         acc = cyc;
      end
      set_in(k, d, 1'b0);
   endtask

   task automatic wait_idle(input int k, output int busy_cnt);
      int guard;
      busy_cnt = 0;
      guard    = 0;
      while (!(qsize(k) == 0 && get_busy(k) === 1'b0 && busy_cnt > 0) && guard < 6000) begin
         @(negedge clk);
         if (get_busy(k) === 1'b1) busy_cnt++;
         guard++;
      end
      if (guard >= 6000) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout dut%0d: busy=%b queued=%0d required busy=0 queued=0", k, get_busy(k), qsize(k));
      end
   endtask

   task automatic run_monitor(input int k);
      exp_t        e;
      int          wait_cyc, last_end, first, bad, busy_bad;
      logic [15:0] seen;
      wait_cyc = 0;
      last_end = -10;
      while (!done) begin
         @(negedge clk);
         if (mon_en[k] == 1'b0) begin
            wait_cyc = 0;
            continue;
         end
         if (get_tx(k) === 1'b0) begin
            if (qsize(k) == 0) begin
               checks++;
               failures++;
               $display("FAIL idle_line dut%0d cycle %0d: tx=0 required=1 with nothing queued", k, cyc);
               for (int g = 0; g < 1000 && get_tx(k) === 1'b0; g++) @(negedge clk);
            end else begin
               e     = qpop(k);
               first = cyc;
               if (e.start_cyc >= 0) begin
                  checks++;
                  if (first != e.start_cyc) begin
                     failures++;
                     $display("FAIL start_latency frame%0d dut%0d: start cycle %0d required %0d", e.id, k, first, e.start_cyc);
                  end
               end
               if (e.contig) begin
                  checks++;
                  if (first != last_end + 1) begin
                     failures++;
                     $display("FAIL frame_gap frame%0d dut%0d: start cycle %0d required %0d", e.id, k, first, last_end + 1);
                  end
               end
               bad      = 0;
               busy_bad = 0;
               seen     = '0;
               for (int i = 0; i < e.ncyc; i++) begin
                  if (i > 0) @(negedge clk);
                  if (get_tx(k) !== e.bits[i / BIT_CYC]) bad++;
                  if ((i % BIT_CYC) == BIT_CYC / 2) seen[i / BIT_CYC] = get_tx(k);
                  if (get_busy(k) !== 1'b1) busy_bad++;
               end
               last_end = first + e.ncyc - 1;
               checks++;
               if (bad != 0) begin
                  failures++;
                  $display("FAIL frame_bits frame%0d dut%0d: line %b required %b (%0d bad samples)", e.id, k, seen, e.bits, bad);
               end
               checks++;
               if (busy_bad != 0) begin
                  failures++;
                  $display("FAIL frame_busy frame%0d dut%0d: busy low %0d cycles required 0", e.id, k, busy_bad);
               end
               wait_cyc = 0;
            end
         end else if (qsize(k) != 0) begin
            wait_cyc++;
            if (wait_cyc > 3000) begin
               e = qpop(k);
               checks++;
               failures++;
               $display("FAIL start_timeout frame%0d dut%0d: line stayed %b required start bit", e.id, k, get_tx(k));
               wait_cyc = 0;
            end
         end else begin
            wait_cyc = 0;
         end
      end
   endtask

   initial begin
      fork
         run_monitor(0);
         run_monitor(1);
         run_monitor(2);
         run_monitor(3);
      join_none
   end

   initial begin
      int            acc, acc0, bc, guard;
      logic [8:0]    burst [5];
      burst = '{9'h011, 9'h080, 9'h0FF, 9'h000, 9'h05A};
      rst_a = 1'b0; rst_o = 1'b0; brk_po = 1'b0;
      v_a = 1'b0; v_po = 1'b0; v_pe = 1'b0; v_s2 = 1'b0;
      d_a = '0; d_po = '0; d_pe = '0; d_s2 = '0;
      #1;
      rst_a = 1'b1;
      rst_o = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_tx", tx_a, 1);
      chk("reset_busy", busy_a, 0);
      chk("reset_ready", rdy_a, 1);
      chk("reset_level", lvl_a, 0);
      rst_a = 1'b0;
      rst_o = 1'b0;
      @(negedge clk);

      // Single 8N1 frame of A5
      do_push(0, 9'h0A5, acc);
      enq(0, 9'h0A5, 1'b0, acc + 2, 0);
      wait_idle(0, bc);
      chk("a5_busy_cycles", bc, 500);

      // Odd and even parity, second word queued behind the first
      do_push(1, 9'h003, acc);
      enq(1, 9'h003, 1'b0, acc + 2, 0);
      do_push(1, 9'h007, acc);
      enq(1, 9'h007, 1'b1, -1, 0);
      do_push(2, 9'h003, acc);
      enq(2, 9'h003, 1'b0, acc + 2, 0);
      do_push(2, 9'h007, acc);
      enq(2, 9'h007, 1'b1, -1, 0);
      wait_idle(1, bc);
      wait_idle(2, bc);

      // 5 data bits, 2 stop bits
      do_push(3, 9'h01F, acc);
      enq(3, 9'h01F, 1'b0, acc + 2, 0);
      do_push(3, 9'h00A, acc);
      enq(3, 9'h00A, 1'b1, -1, 0);
      wait_idle(3, bc);
      chk("s2_busy_cycles", bc, 800);

      // Burst of 5 into a depth-4 FIFO
      for (int i = 0; i < 5; i++) begin
         do_push(0, burst[i], acc);
         enq(0, burst[i], (i != 0), (i == 0) ? acc + 2 : -1, 0);
         if (i == 1) chk("push_pop_level", lvl_a, 1);
      end
      chk("burst_level_full", lvl_a, 4);
      chk("burst_ready_low", rdy_a, 0);
      set_in(0, 9'h0C3, 1'b1);
      repeat (20) @(negedge clk);
      set_in(0, 9'h0C3, 1'b0);
      chk("blocked_push_level", lvl_a, 4);
      wait_idle(0, bc);

      // Reset 120 clocks into a frame with a second word queued
      do_push(0, 9'h000, acc0);
      enq(0, 9'h000, 1'b0, acc0 + 2, 120);
      do_push(0, 9'h099, acc);
      chk("pre_reset_level", lvl_a, 1);
      guard = 0;
      while (cyc < acc0 + 2 + 119 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      #2;
      rst_a = 1'b1;
      #1;
      chk("midreset_tx", tx_a, 1);
      chk("midreset_level", lvl_a, 0);
      chk("midreset_busy", busy_a, 0);
      chk("midreset_ready", rdy_a, 1);
      @(negedge clk);
      rst_a = 1'b0;
      repeat (300) @(negedge clk);
      chk("post_reset_level", lvl_a, 0);
      chk("post_reset_busy", busy_a, 0);

`ifdef UART_TX_BUF_BREAK_EN
      mon_en[1] = 1'b0;
      brk_po = 1'b1;
      repeat (3) @(negedge clk);
      do_push(1, 9'h03C, acc);
      repeat (200) @(negedge clk);
      chk("break_line_low", tx_po, 0);
      chk("break_level", lvl_po, 1);
      chk("break_busy", busy_po, 0);
      enq(1, 9'h03C, 1'b0, cyc + 2, 0);
      brk_po = 1'b0;
      #1;
      mon_en[1] = 1'b1;
      wait_idle(1, bc);
`endif

      guard = 0;
      while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) != 0 && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 6000) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d frames still queued required 0", qsize(0) + qsize(1) + qsize(2) + qsize(3));
      end
      repeat (60) @(negedge clk);
      done = 1'b1;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
